// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types, constants and operand unpacking
// for the pipelined add/subtract unit.
package fp_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Operand after denormal flush: significand carries the hidden bit.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   sig;
    } fp_unpacked_t;

    // Result decided in S1 (NaN/inf/zero cases) that bypasses the datapath.
    typedef struct packed {
        logic      hit;
        fp32_t     res;
        fp_flags_t flg;
    } fp_special_t;

    // Denormals become signed zero; flip applies the subtract to operand B.
    function automatic fp_unpacked_t unpack_op(input logic [31:0] x, input logic flip);
        fp_unpacked_t u;
        u.sign = x[31] ^ flip;
        u.exp  = x[30:23];
        u.sig  = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns IN_W.
module fp_lzc
    import fp_pkg::*;
#(
    parameter int IN_W  = 28,
    parameter int OUT_W = 5
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_count
);

    // Scan upward so the highest set bit has the final say.
    always_comb begin
        o_count = OUT_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            if (i_data[i]) o_count = OUT_W'(IN_W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754 single add/subtract: 5 core stages plus LATENCY-5 delay
// stages, RNE rounding, flush-to-zero, one global advance for backpressure.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      dataa,
    input  logic [31:0]      datab,
    input  logic             op_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags
);

    localparam int EXTRA = LATENCY - 5;

    // RNE on the 27-bit normalised significand {hidden, man[22:0], G, R, S};
    // returns {flags, result} including overflow/underflow saturation.
    function automatic logic [35:0] round_pack(input logic sign,
                                               input logic signed [9:0] exp_n,
                                               input logic [26:0] norm);
        logic [24:0]       rnd;
        logic              up;
        logic              inx;
        logic signed [9:0] exp_r;
        inx   = |norm[2:0];
        up    = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd   = {1'b0, norm[26:3]} + {24'd0, up};
        exp_r = exp_n + (rnd[24] ? 10'sd1 : 10'sd0);
        if (exp_n <= 10'sd0)
            return {4'b0011, sign, 31'd0};
        else if (exp_r >= 10'sd255)
            return {4'b0101, sign, 8'hFF, 23'd0};
        else
            return {3'b000, inx, sign, exp_r[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
    endfunction

    logic w_advance;

    logic             r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
    logic [TAG_W-1:0] r_tag_p1, r_tag_p2, r_tag_p3, r_tag_p4;
    fp_special_t      r_spec_p1, r_spec_p2, r_spec_p3, r_spec_p4;

    fp_unpacked_t r_big_p1;
    logic [7:0]   r_sm_exp_p1;
    logic [23:0]  r_sm_sig_p1;
    logic         r_eff_sub_p1;

    logic         r_sign_p2, r_eff_sub_p2;
    logic [7:0]   r_exp_p2;
    logic [26:0]  r_sig_l_p2, r_sig_s_p2;

    logic         r_sign_p3;
    logic [7:0]   r_exp_p3;
    logic [27:0]  r_sum_p3;

    logic              r_sign_p4, r_zero_p4;
    logic signed [9:0] r_exp_p4;
    logic [26:0]       r_norm_p4;

    logic             r_vld_q [0:EXTRA];
    fp32_t            r_res_q [0:EXTRA];
    logic [TAG_W-1:0] r_tag_q [0:EXTRA];
    fp_flags_t        r_flg_q [0:EXTRA];

    fp_unpacked_t w_a, w_b, w_big;
    logic [7:0]   w_sm_exp;
    logic [23:0]  w_sm_sig;
    logic         w_swap, w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    fp_special_t  w_spec;

    logic [7:0]   w_d;
    logic [53:0]  w_al;
    logic [26:0]  w_sig_s;
    logic [27:0]  w_sum;

    logic [4:0]        w_lz;
    logic signed [9:0] w_exp_n;
    logic [26:0]       w_norm;

    logic [35:0]  w_rp;
    fp32_t        w_s5_res;
    fp_flags_t    w_s5_flg;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_vld_q[EXTRA];
    assign result    = r_res_q[EXTRA];
    assign out_tag   = r_tag_q[EXTRA];
    assign flags     = r_flg_q[EXTRA];

    assign w_nan_a  = (&dataa[30:23]) &  (|dataa[22:0]);
    assign w_nan_b  = (&datab[30:23]) &  (|datab[22:0]);
    assign w_inf_a  = (&dataa[30:23]) & ~(|dataa[22:0]);
    assign w_inf_b  = (&datab[30:23]) & ~(|datab[22:0]);
    assign w_zero_a = ~(|dataa[30:23]);
    assign w_zero_b = ~(|datab[30:23]);

    // ---- S1: unpack, classify specials, order operands by magnitude ----
    always_comb begin
        w_a      = unpack_op(dataa, 1'b0);
        w_b      = unpack_op(datab, op_sub);
        w_swap   = {w_b.exp, w_b.sig} > {w_a.exp, w_a.sig};
        w_big    = w_swap ? w_b : w_a;
        w_sm_exp = w_swap ? w_a.exp : w_b.exp;
        w_sm_sig = w_swap ? w_a.sig : w_b.sig;
        w_spec   = '0;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_a.sign != w_b.sign))) begin
            w_spec.hit         = 1'b1;
            w_spec.res         = fp32_t'(QNAN);
            w_spec.flg.invalid = 1'b1;
        end else if (w_inf_a) begin
            w_spec.hit = 1'b1;
            w_spec.res = {w_a.sign, 8'hFF, 23'd0};
        end else if (w_inf_b) begin
            w_spec.hit = 1'b1;
            w_spec.res = {w_b.sign, 8'hFF, 23'd0};
        end else if (w_zero_a && w_zero_b) begin
            w_spec.hit = 1'b1;
            w_spec.res = {w_a.sign & w_b.sign, 31'd0};
        end
    end

    // ---- S2: align smaller significand with guard/round/sticky ----
    always_comb begin
        w_d     = r_big_p1.exp - r_sm_exp_p1;
        w_al    = {r_sm_sig_p1, 30'd0} >> w_d;
        w_sig_s = (w_d >= 8'd27) ? {26'd0, |r_sm_sig_p1}
                                 : {w_al[53:28], w_al[27] | (|w_al[26:0])};
    end

    // ---- S3: magnitude add/subtract (|big| >= |small| so never negative) ----
    assign w_sum = r_eff_sub_p2 ? ({1'b0, r_sig_l_p2} - {1'b0, r_sig_s_p2})
                                : ({1'b0, r_sig_l_p2} + {1'b0, r_sig_s_p2});

    // ---- S4: normalise ----
    fp_lzc #(.IN_W(28), .OUT_W(5)) u_lzc (
        .i_data  (r_sum_p3),
        .o_count (w_lz)
    );

    // Carry-out shifts right keeping sticky; otherwise bring the MSB to bit 26.
    always_comb begin
        if (r_sum_p3[27]) begin
            w_norm  = {r_sum_p3[27:2], r_sum_p3[1] | r_sum_p3[0]};
            w_exp_n = $signed({2'b00, r_exp_p3}) + 10'sd1;
        end else begin
            w_norm  = 27'(r_sum_p3 << (w_lz - 5'd1));
            w_exp_n = $signed({2'b00, r_exp_p3}) - $signed({5'd0, w_lz}) + 10'sd1;
        end
    end

    // ---- S5: round, pack, pick special or exact-zero result ----
    always_comb begin
        w_rp = round_pack(r_sign_p4, r_exp_p4, r_norm_p4);
        if (r_spec_p4.hit) begin
            w_s5_res = r_spec_p4.res;
            w_s5_flg = r_spec_p4.flg;
        end else if (r_zero_p4) begin
            w_s5_res = '0;
            w_s5_flg = '0;
        end else begin
            w_s5_flg = fp_flags_t'(w_rp[35:32]);
            w_s5_res = fp32_t'(w_rp[31:0]);
        end
    end

    // Core stage valid bits: flushed by reset, shifted together on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
            r_vld_p4 <= 1'b0;
        end else if (w_advance) begin
            r_vld_p1 <= in_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
            r_vld_p4 <= r_vld_p3;
        end
    end

    // Core stage data: no reset, qualified by the valid bits above.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_tag_p1     <= in_tag;
            r_spec_p1    <= w_spec;
            r_big_p1     <= w_big;
            r_sm_exp_p1  <= w_sm_exp;
            r_sm_sig_p1  <= w_sm_sig;
            r_eff_sub_p1 <= w_a.sign ^ w_b.sign;

            r_tag_p2     <= r_tag_p1;
            r_spec_p2    <= r_spec_p1;
            r_sign_p2    <= r_big_p1.sign;
            r_exp_p2     <= r_big_p1.exp;
            r_sig_l_p2   <= {r_big_p1.sig, 3'b000};
            r_sig_s_p2   <= w_sig_s;
            r_eff_sub_p2 <= r_eff_sub_p1;

            r_tag_p3     <= r_tag_p2;
            r_spec_p3    <= r_spec_p2;
            r_sign_p3    <= r_sign_p2;
            r_exp_p3     <= r_exp_p2;
            r_sum_p3     <= w_sum;

            r_tag_p4     <= r_tag_p3;
            r_spec_p4    <= r_spec_p3;
            r_sign_p4    <= r_sign_p3;
            r_exp_p4     <= w_exp_n;
            r_norm_p4    <= w_norm;
            r_zero_p4    <= (r_sum_p3 == 28'd0);
        end
    end

    // Result register plus delay stages; reset so outputs read zero in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= EXTRA; i++) begin
                r_vld_q[i] <= 1'b0;
                r_res_q[i] <= '0;
                r_tag_q[i] <= '0;
                r_flg_q[i] <= '0;
            end
        end else if (w_advance) begin
            r_vld_q[0] <= r_vld_p4;
            r_res_q[0] <= w_s5_res;
            r_tag_q[0] <= r_tag_p4;
            r_flg_q[0] <= w_s5_flg;
            for (int i = 1; i <= EXTRA; i++) begin
                r_vld_q[i] <= r_vld_q[i-1];
                r_res_q[i] <= r_res_q[i-1];
                r_tag_q[i] <= r_tag_q[i-1];
                r_flg_q[i] <= r_flg_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed vectors, backpressure, reset.
module tb_fp_addsub_pipe;

    localparam int LATENCY = 10;
    localparam int TAG_W   = 8;
    localparam int NV      = 16;

    localparam logic [31:0] VA [0:NV-1] = '{
        32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h3F800000,
        32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001,
        32'h7F800000, 32'h80000000, 32'h00000000, 32'h00800000,
        32'h00800001, 32'h00000001, 32'h40000000, 32'h3F800000};
    localparam logic [31:0] VB [0:NV-1] = '{
        32'h40000000, 32'h3F800000, 32'h3FA00000, 32'h33800000,
        32'h33800001, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
        32'h3F800000, 32'h80000000, 32'h80000000, 32'h01000000,
        32'h00800000, 32'h3F800000, 32'h3F800000, 32'hC0000000};
    localparam bit VS [0:NV-1] = '{
        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] ER [0:NV-1] = '{
        32'h40400000, 32'h00000000, 32'h3E800000, 32'h3F800000,
        32'h3F800001, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
        32'h7F800000, 32'h80000000, 32'h00000000, 32'h80800000,
        32'h00000000, 32'h3F800000, 32'h3F800000, 32'hBF800000};
    localparam logic [3:0] EF [0:NV-1] = '{
        4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h5, 4'h8, 4'h8,
        4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      dataa = '0;
    logic [31:0]      datab = '0;
    logic             op_sub = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      result;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       flags;

    fp_addsub_pipe #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataa     (dataa),
        .datab     (datab),
        .op_sub    (op_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flg;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   cur_v = 0;
    bit   acc_now = 1'b0;
    bit   lat_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input int v, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        dataa    = VA[v];
        datab    = VB[v];
        op_sub   = VS[v];
        in_tag   = tag;
        cur_v    = v;
    endtask

    // One clock cycle: observe outputs and accepts between edges, then advance.
    task automatic tick();
        exp_t e;
        #1;
        acc_now = 1'b0;
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("tag", 32'(out_tag), 32'(e.tag));
                check("flags", 32'(flags), 32'(e.flg));
                if (e.lat) check("latency", 32'(cyc - e.acc), 32'(LATENCY));
            end
        end
        if (in_valid && in_ready) begin
            acc_now = 1'b1;
            e.res = ER[cur_v];
            e.tag = in_tag;
            e.flg = EF[cur_v];
            e.acc = cyc;
            e.lat = lat_mode;
            sb.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 60 && sb.size() > 0; k++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int idx;
        int n0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Single op: 1.0 + 2.0 with tag 0x5A, latency checked
        lat_mode  = 1'b1;
        out_ready = 1'b1;
        drive(0, 8'h5A);
        tick();
        drain();

        // All directed vectors back to back
        for (int v = 0; v < NV; v++) begin
            drive(v, TAG_W'(8'h10 + v));
            tick();
        end
        drain();

        // Backpressure: 12 ops, consumer stalls for cycles 12..15
        lat_mode = 1'b0;
        idx = 0;
        n0 = n_out;
        for (int lc = 0; lc < 80 && (idx < 12 || sb.size() > 0); lc++) begin
            out_ready = !(lc >= 12 && lc <= 15);
            if (idx < 12) drive(idx % NV, TAG_W'(idx));
            else in_valid = 1'b0;
            if (!out_ready) begin
                #1;
                check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                if (sb.size() > 0) begin
                    check("hold_tag", 32'(out_tag), 32'(sb[0].tag));
                    check("hold_result", result, sb[0].res);
                    check("hold_flags", 32'(flags), 32'(sb[0].flg));
                end
            end
            tick();
            if (acc_now) idx++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check("bp_count", 32'(n_out - n0), 32'd12);
        check("bp_empty", 32'(sb.size()), 32'd0);

        // Reset mid-flight: in-flight ops discarded, no outputs
        lat_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(i, TAG_W'(8'hA0 + i));
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("midrst_hold_valid", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n0 = n_out;
        repeat (15) tick();
        check("post_rst_no_out", 32'(n_out - n0), 32'd0);
        drive(0, 8'hC3);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("post_rst_one_out", 32'(n_out - n0), 32'd1);
        check("post_rst_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
